// File: rtl/music_sequencer_if.sv
// Note-ROM bus between the playback sequencer (master) and the registered note ROM (slave).
interface music_sequencer_if #(
  parameter int AW = 8
);
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;

  modport master (output rom_addr, input  rom_data);
  modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/music_sequencer.sv
// Music box playback controller: walks a per-track note table, times each note and its
// articulation gap, and handles play/pause plus previous/next track selection.
module music_sequencer #(
  parameter int TRACK_BITS = 2,
  parameter int NOTE_AW    = 6,
  parameter int TICK_DIV   = 12_500_000,
  parameter int GAP_CYC    = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  play,
  input  logic                  next,
  input  logic                  prev,
  music_sequencer_if.master     rom,
  output logic [4:0]            factor,
  output logic                  tone_en,
  output logic [TRACK_BITS-1:0] track,
  output logic [NOTE_AW-1:0]    note_idx,
  output logic                  track_done
);
  localparam int AW     = TRACK_BITS + NOTE_AW;
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [4:0]        CODE_END  = 5'd31;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP} state_e;

  typedef struct packed {
    logic [2:0] dur;
    logic [4:0] code;
  } note_word_t;

  state_e                state_q, state_d;
  logic [TRACK_BITS-1:0] track_q, track_d;
  logic [NOTE_AW-1:0]    note_idx_q, note_idx_d;
  logic [4:0]            factor_q, factor_d;
  logic [AW-1:0]         rom_addr_q, rom_addr_d;
  logic [3:0]            dur_cnt_q, dur_cnt_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  track_done_q, track_done_d;

  note_word_t word;
  logic       sw_next, sw_prev;

  assign word    = rom.rom_data;
  // Simultaneous next+prev cancel out and fall through to normal state activity.
  assign sw_next = next & ~prev;
  assign sw_prev = prev & ~next;

  always_comb begin
    state_d      = state_q;
    track_d      = track_q;
    note_idx_d   = note_idx_q;
    factor_d     = factor_q;
    dur_cnt_d    = dur_cnt_q;
    tick_cnt_d   = tick_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    track_done_d = 1'b0;

    if (sw_next || sw_prev) begin
      track_d    = sw_next ? track_q + 1'b1 : track_q - 1'b1;
      note_idx_d = '0;
      factor_d   = '0;
      dur_cnt_d  = '0;
      tick_cnt_d = '0;
      gap_cnt_d  = '0;
      state_d    = play ? S_FETCH : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (play) state_d = S_FETCH;
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          if (word.code == CODE_END) begin
            track_done_d = 1'b1;
            note_idx_d   = '0;
            state_d      = S_FETCH;
          end else begin
            factor_d   = word.code;
            dur_cnt_d  = {1'b0, word.dur} + 4'd1;
            tick_cnt_d = '0;
            state_d    = S_PLAY;
          end
        end
        S_PLAY: begin
          if (play) begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_d = '0;
              dur_cnt_d  = dur_cnt_q - 4'd1;
              if (dur_cnt_q == 4'd1) begin
                gap_cnt_d = '0;
                state_d   = S_GAP;
              end
            end else begin
              tick_cnt_d = tick_cnt_q + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (play) begin
            if (gap_cnt_q == GAP_LAST) begin
              gap_cnt_d  = '0;
              note_idx_d = note_idx_q + 1'b1;
              state_d    = S_FETCH;
            end else begin
              gap_cnt_d = gap_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Address tracks the next-cycle position so the ROM word is ready by LOAD.
    rom_addr_d = {track_d, note_idx_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      track_q      <= '0;
      note_idx_q   <= '0;
      factor_q     <= '0;
      rom_addr_q   <= '0;
      dur_cnt_q    <= '0;
      tick_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      track_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      track_q      <= track_d;
      note_idx_q   <= note_idx_d;
      factor_q     <= factor_d;
      rom_addr_q   <= rom_addr_d;
      dur_cnt_q    <= dur_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      track_done_q <= track_done_d;
    end
  end

  assign rom.rom_addr = rom_addr_q;
  assign factor       = factor_q;
  assign track        = track_q;
  assign note_idx     = note_idx_q;
  assign track_done   = track_done_q;
  // Pause gates the tone combinationally so it silences in the same cycle.
  assign tone_en      = (state_q == S_PLAY) & play & (factor_q != 5'd0);

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: directed scenarios plus randomized play/track/reset traffic,
// all compared against a remaining-cycles playback model.
module tb_music_sequencer;
  localparam int TB = 2, NA = 6, TD = 4, GC = 2;
  localparam int NT = 1 << TB, NN = 1 << NA;
  localparam int P_IDLE = 0, P_FETCH = 1, P_LOAD = 2, P_PLAY = 3, P_GAP = 4;

  logic clk = 1'b0, rst = 1'b0, play = 1'b0, nxt = 1'b0, prv = 1'b0;
  logic [4:0]    factor;
  logic          tone_en, track_done;
  logic [TB-1:0] track;
  logic [NA-1:0] note_idx;
  logic [7:0]    mem [NT*NN];

  int n_chk = 0, n_bad = 0;
  int m_track, m_idx, m_factor, m_phase, m_rem, m_done;
  int hi, first, ndone, done_at, prev_idx, wrapped;

  music_sequencer_if #(.AW(TB+NA)) rom_if ();

  music_sequencer #(.TRACK_BITS(TB), .NOTE_AW(NA), .TICK_DIV(TD), .GAP_CYC(GC)) dut (
    .clk(clk), .rst(rst), .play(play), .next(nxt), .prev(prv), .rom(rom_if),
    .factor(factor), .tone_en(tone_en), .track(track), .note_idx(note_idx),
    .track_done(track_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_if.rom_data <= mem[rom_if.rom_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Playback model: a note is just a count of remaining audible/gap cycles.
  task automatic model_step();
    logic [7:0] w;
    m_done = 0;
    if (rst) begin
      m_track = 0; m_idx = 0; m_factor = 0; m_phase = P_IDLE; m_rem = 0;
    end else if (nxt != prv) begin
      m_track  = (m_track + (nxt ? 1 : NT - 1)) % NT;
      m_idx    = 0; m_factor = 0; m_rem = 0;
      m_phase  = play ? P_FETCH : P_IDLE;
    end else begin
      case (m_phase)
        P_IDLE:  if (play) m_phase = P_FETCH;
        P_FETCH: m_phase = P_LOAD;
        P_LOAD: begin
          w = mem[m_track*NN + m_idx];
          if (w[4:0] == 5'd31) begin
            m_done = 1; m_idx = 0; m_phase = P_FETCH;
          end else begin
            m_factor = int'(w[4:0]);
            m_rem    = (int'(w[7:5]) + 1) * TD;
            m_phase  = P_PLAY;
          end
        end
        P_PLAY: if (play) begin
          m_rem--;
          if (m_rem == 0) begin m_phase = P_GAP; m_rem = GC; end
        end
        P_GAP: if (play) begin
          m_rem--;
          if (m_rem == 0) begin m_idx = (m_idx + 1) % NN; m_phase = P_FETCH; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_outs();
    chk("factor",     32'(factor),          32'(m_factor));
    chk("tone_en",    32'(tone_en),         32'((m_phase == P_PLAY) && play && (m_factor != 0)));
    chk("track",      32'(track),           32'(m_track));
    chk("note_idx",   32'(note_idx),        32'(m_idx));
    chk("track_done", 32'(track_done),      32'(m_done));
    chk("rom_addr",   32'(rom_if.rom_addr), 32'(m_track*NN + m_idx));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outs();
  endtask

  task automatic do_reset();
    rst = 1'b1; play = 1'b0; nxt = 1'b0; prv = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse(input logic n, input logic p);
    nxt = n; prv = p;
    step();
    nxt = 1'b0; prv = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NT*NN; i++) mem[i] = 8'h1F;
    mem[0] = 8'h25; mem[1] = 8'h00; mem[2] = 8'h1F;
    mem[2*NN] = 8'h2A;

    // reset state
    do_reset();
    chk("rst_outs", 32'({factor, tone_en, track, note_idx, track_done, rom_if.rom_addr}), 32'd0);

    // basic playback, end marker and repeat
    play = 1'b1; hi = 0; first = -1; ndone = 0; done_at = -1;
    for (int i = 0; i < 26; i++) begin
      step();
      if (i <= 21 && tone_en) begin hi++; if (first < 0) first = i; end
      if (track_done) begin ndone++; done_at = i; end
      if (i == 14) begin
        chk("rest_factor", 32'(factor), 32'd0);
        chk("rest_idx", 32'(note_idx), 32'd1);
      end
      if (i == 24) begin
        chk("replay_tone", 32'(tone_en), 32'd1);
        chk("replay_factor", 32'(factor), 32'd5);
        chk("replay_idx", 32'(note_idx), 32'd0);
      end
    end
    chk("first_high", 32'(first), 32'd2);
    chk("note_highs", 32'(hi), 32'd8);
    chk("done_count", 32'(ndone), 32'd1);
    chk("done_at", 32'(done_at), 32'd22);

    // pause mid-note and resume
    do_reset();
    play = 1'b1;
    repeat (5) step();
    play = 1'b0;
    #1;
    chk("pause_tone", 32'(tone_en), 32'd0);
    chk("pause_factor", 32'(factor), 32'd5);
    hi = 0;
    repeat (10) begin step(); hi += int'(tone_en); end
    chk("paused_highs", 32'(hi), 32'd0);
    chk("paused_factor", 32'(factor), 32'd5);
    play = 1'b1; hi = 0;
    repeat (12) begin step(); hi += int'(tone_en); end
    chk("resume_highs", 32'(hi), 32'd5);

    // track select
    do_reset();
    play = 1'b1;
    repeat (5) step();
    pulse(1'b1, 1'b0);
    chk("next_track", 32'(track), 32'd1);
    chk("next_addr", 32'(rom_if.rom_addr), 32'h40);
    chk("next_tone", 32'(tone_en), 32'd0);
    do_reset();
    pulse(1'b0, 1'b1);
    chk("prev_wrap", 32'(track), 32'd3);
    pulse(1'b1, 1'b1);
    chk("both_ignored", 32'(track), 32'd3);

    // reset mid-note on track 2
    do_reset();
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    play = 1'b1;
    repeat (4) step();
    chk("t2_playing", 32'({tone_en, factor, track}), 32'({1'b1, 5'd10, 2'd2}));
    rst = 1'b1;
    step();
    rst = 1'b0; play = 1'b0;
    chk("midnote_rst", 32'({factor, tone_en, track, note_idx, track_done, rom_if.rom_addr}), 32'd0);
    repeat (3) step();

    // next while idle: track moves, nothing plays
    pulse(1'b1, 1'b0);
    chk("idle_next", 32'(track), 32'd1);
    hi = 0;
    repeat (5) begin step(); hi += int'(tone_en); end
    chk("idle_silent", 32'({hi[3:0], note_idx}), 32'd0);

    // marker-free track 1: index wraps with no track_done
    for (int i = 0; i < NN; i++) mem[NN + i] = {3'b000, 5'($urandom_range(1, 30))};
    do_reset();
    pulse(1'b1, 1'b0);
    play = 1'b1; wrapped = 0; ndone = 0; prev_idx = 0;
    for (int i = 0; i < 1500 && wrapped == 0; i++) begin
      step();
      if (track_done) ndone++;
      if (prev_idx == NN - 1 && note_idx == '0) wrapped = 1;
      prev_idx = int'(note_idx);
    end
    chk("wrap_seen", 32'(wrapped), 32'd1);
    chk("wrap_no_done", 32'(ndone), 32'd0);

    // randomized traffic
    for (int i = 0; i < NT*NN; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? {3'($urandom), 5'd31}
                                           : {3'($urandom), 5'($urandom_range(0, 30))};
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 39) == 0) play = ~play;
      nxt = ($urandom_range(0, 149) == 0);
      prv = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/music_sequencer.md
# music_sequencer

Playback controller for the music box. It walks a per-track note table and drives the tone generator's `factor` and enable. It handles play/pause and previous/next track selection from pre-debounced button pulses, and exports the track number and note index so the 7-segment display can show them. It sits between the switch/button front end, the note ROM and the bell tone generator.

## Interface
- `TRACK_BITS`, 2: track select width; number of tracks is 2^TRACK_BITS.
- `NOTE_AW`, 6: note index width; each track holds 2^NOTE_AW words.
- `TICK_DIV`, 12_500_000: clk cycles per duration tick (1/8 s at 100 MHz); ≥2.
- `GAP_CYC`, 1_000_000: silent articulation cycles after every note; ≥1.
- `clk`  in  1  system clock, all logic rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `play`  in  1  level, synchronous: 1 = run, 0 = pause.
- `next`  in  1  one-cycle pulse, advance track.
- `prev`  in  1  one-cycle pulse, previous track.
- `rom_addr`  out  TRACK_BITS+NOTE_AW  `{track, note_idx}`, registered.
- `rom_data`  in  8  note word, valid the cycle after `rom_addr` changes (registered ROM). [7:5] = dur code d, [4:0] = note code.
- `factor`  out  5  note code for the tone generator.
- `tone_en`  out  1  tone generator enable.
- `track`  out  TRACK_BITS  current track.
- `note_idx`  out  NOTE_AW  current note index.
- `track_done`  out  1  one-cycle pulse at end-of-track.

## Operation
- Note codes:
  - 0 = rest (silent, timed normally).
  - 31 = end marker (duration ignored).
  - 1..30 = tones.
- States: IDLE, FETCH, LOAD, PLAY, GAP.
- IDLE:
  - Hold while `play`=0.
  - `play`=1 → FETCH.
- FETCH: `rom_addr` already equals `{track,note_idx}`; wait one cycle → LOAD.
- LOAD, note code 31:
  - Pulse `track_done`.
  - `note_idx`←0.
  - Go to FETCH; the track repeats.
- LOAD, any other code:
  - `factor`←code.
  - `dur_cnt`←d+1.
  - `tick_cnt`←0.
  - Go to PLAY.
- PLAY:
  - When `play`=1, `tick_cnt` increments.
  - At `tick_cnt`=TICK_DIV-1: `tick_cnt`←0 and `dur_cnt` decrements.
  - When `dur_cnt` reaches 0 → GAP with `gap_cnt`←0.
- GAP:
  - `gap_cnt` counts while `play`=1.
  - At GAP_CYC-1: `note_idx`←`note_idx`+1, wrapping 2^NOTE_AW-1→0 with no `track_done`; then → FETCH.
- `tone_en` = (state==PLAY) & `play` & (`factor`≠0).
  - Rests and gaps are silent.
  - Pause silences immediately.
- Pause (`play`=0):
  - In PLAY or GAP, all counters freeze and `factor` holds.
  - In FETCH or LOAD, the fetch completes into PLAY, then freezes.
  - On resume, timing continues from the frozen counts.
- `next`/`prev` act in any state:
  - `track`±1 modulo 2^TRACK_BITS.
  - `note_idx`←0, counters←0, `factor`←0.
  - State → FETCH if `play`=1, else IDLE.
  - Priority over all state activity, including the LOAD of an end marker: no `track_done` is issued that cycle.
  - `next` and `prev` high in the same cycle: both ignored.
- `rst` (any state, including mid-note) has priority over everything:
  - State IDLE.
  - `track`=0, `note_idx`=0, `factor`=0, `rom_addr`=0.
  - `tone_en`=0, `track_done`=0.
  - All counters 0.

## Timing
- `play` sampled 1 in IDLE at edge k:
  - FETCH after k, LOAD after k+1, PLAY after k+2.
  - `tone_en`=1 from edge k+2.
- Note with dur code d, uninterrupted:
  - PLAY lasts exactly (d+1)·TICK_DIV cycles.
  - GAP lasts GAP_CYC cycles.
  - FETCH+LOAD take 2 cycles.
  - Note-to-note period = (d+1)·TICK_DIV + GAP_CYC + 2.
- End marker costs 2 extra cycles (FETCH+LOAD of the marker itself).
- Track switch:
  - `tone_en`=0 and new `rom_addr` from the edge after the pulse.
  - First note of the new track is audible 2 cycles later if playing.
- `track_done` is high exactly one cycle, in the cycle after LOAD of code 31.

## Test plan
Bench parameters: TICK_DIV=4, GAP_CYC=2.

- Basic playback: track 0 = {8'h25, 8'h00, 8'h1F}, rst then `play`=1 at edge k → `tone_en`=1, `factor`=5 for 8 cycles from k+2; then 2 gap + 2 fetch cycles low; then rest `factor`=0, `tone_en`=0 for 4 cycles.
- End marker and wrap:
  - Continuing the above: `track_done` pulses once; `note_idx` returns 0; `factor`=5 again 2 cycles later.
  - Separate run, table without marker: `note_idx` wraps 63→0 with no `track_done`.
- Pause: drop `play` after 3 cycles of note 5, hold 10 cycles → `tone_en`=0 immediately and `factor` stays 5; on resume, exactly 5 more high cycles.
- Track select:
  - `next` mid-note → `track`=1, `rom_addr`=8'h40, `tone_en`=0 next cycle.
  - `prev` from track 0 → `track`=3.
  - `next`+`prev` together → no change.
- Reset mid-note: `rst` during PLAY on track 2 → next cycle all outputs 0 and state IDLE; no `track_done`.
- Idle: `next` while `play`=0 → `track` increments, `tone_en` stays 0, no ROM fetch until `play`=1.
